// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared state enum and default widths for the sum accumulator
package sum_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_IN_W   = 10;
  localparam int DEF_ACC_W  = 12;
  localparam int DEF_LOG2_N = 3;

endpackage

// File: rtl/sum_acc_add.sv
// rtl/sum_acc_add.sv - accumulator adder with carry out; clamps when SUM_ACC_SATURATE_EN is defined
module sum_acc_add #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W-1:0] raw;

  always_comb begin
    {carry, raw} = {1'b0, a} + {1'b0, b};
`ifdef SUM_ACC_SATURATE_EN
    sum = carry ? {ACC_W{1'b1}} : raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - N-sample block accumulator with ready/valid handshake
// Optional saturation of the running total via SUM_ACC_SATURATE_EN.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [IN_W-1:0]     in_sum,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    acc_sum,
  output logic [ACC_W-LOG2_N-1:0] avg,
  output logic                ovf
);

  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    add_sum;
  logic                add_carry;

  assign addend = {{(ACC_W-IN_W){1'b0}}, in_sum};

  sum_acc_add #(.ACC_W(ACC_W)) u_add (
    .a     (acc_q),
    .b     (addend),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      // clr wins over sample acceptance and over a pending handshake
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_carry;
            cnt_d = cnt_q + {{(LOG2_N-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign acc_sum   = acc_q;
  assign avg       = acc_q[ACC_W-1:LOG2_N];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - scoreboard bench for sum_accumulator with directed blocks
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  in_sum = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] acc_sum;
  logic [8:0]  avg;
  logic        ovf;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [11:0] acc;
    logic [8:0]  avg;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  sum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_sum   (acc_sum),
    .avg       (avg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [11:0] a, input logic [8:0] v, input logic o);
    exp_t e;
    e.acc = a;
    e.avg = v;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [9:0] v);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_sum   = v;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [9:0] v);
    for (int i = 0; i < n; i++) send(v);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_acc_sum", acc_sum, e.acc);
        chk("mon_avg", avg, e.avg);
        chk("mon_ovf", ovf, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_sum", acc_sum, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back 8 x 100
    push_exp(12'd800, 9'd100, 1'b0);
    send_n(8, 10'd100);
    chk("t1_latency_out_valid", out_valid, 1);
    chk("t1_in_ready_hold", in_ready, 0);
    @(posedge clk);
    #1;
    chk("t1_after_hs_out_valid", out_valid, 0);

    // overflow block
`ifdef SUM_ACC_SATURATE_EN
    push_exp(12'd4095, 9'd511, 1'b1);
`else
    push_exp(12'd4088, 9'd511, 1'b1);
`endif
    send_n(8, 10'd1023);
    chk("t2_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    chk("t2_ovf_cleared", ovf, 0);
    chk("t2_acc_cleared", acc_sum, 0);

    // stall in HOLD while in_valid held
    out_ready = 1'b0;
    send_n(8, 10'd20);
    in_valid = 1'b1;
    in_sum   = 10'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t3_stall_out_valid", out_valid, 1);
      chk("t3_stall_in_ready", in_ready, 0);
      chk("t3_stall_acc", acc_sum, 160);
    end
    in_valid = 1'b0;
    push_exp(12'd160, 9'd20, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_clean_acc", acc_sum, 0);
    chk("t3_clean_in_ready", in_ready, 1);
    push_exp(12'd8, 9'd1, 1'b0);
    send_n(8, 10'd1);
    @(posedge clk);
    #1;

    // clr mid-block, sample offered with clr dropped
    send_n(3, 10'd50);
    chk("t4_partial", acc_sum, 150);
    clr = 1'b1;
    in_valid = 1'b1;
    in_sum = 10'd50;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    chk("t4_clr_acc", acc_sum, 0);
    push_exp(12'd80, 9'd10, 1'b0);
    send_n(8, 10'd10);
    @(posedge clk);
    #1;

    // async reset mid-block
    send_n(5, 10'd300);
    chk("t5_partial", acc_sum, 1500);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_acc", acc_sum, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(12'd56, 9'd7, 1'b0);
    send_n(8, 10'd7);
    @(posedge clk);
    #1;

    // clr in HOLD with out_ready high: result dropped
    out_ready = 1'b0;
    send_n(8, 10'd30);
    chk("t6_hold_acc", acc_sum, 240);
    clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_acc", acc_sum, 0);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
